awg_sample_generator: RTL

- Produces the 8-bit waveform sample consumed by the PCF8591 DAC I2C transmitter. The sample feeds that transmitter's `signal` input.
- Uses an NCO: a phase accumulator advanced once per `advance` strobe. The strobe is driven by the transmitter's byte-accepted indication, so the generator runs at DAC write rate.
- Selectable waveform: sawtooth, triangle, square with duty control, or quarter-wave-LUT sine.
- Amplitude is scaled about midscale 128.

---
 rtl/awg_sample_generator.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/awg_sample_generator.sv
// NCO-based waveform generator feeding the PCF8591 DAC transmitter.
// Three-stage pipeline: phase accumulate, waveform shaping, amplitude scaling.
module awg_sample_generator #(
  parameter int PHASE_W = 24,
  parameter int LUT_AW  = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               advance,
  input  logic [PHASE_W-1:0] tune_word,
  input  logic [1:0]         wave_sel,
  input  logic [7:0]         duty,
  input  logic [7:0]         amplitude,
  output logic [7:0]         sample,
  output logic               sample_valid,
  output logic               phase_wrap
);

  localparam logic [1:0] WAVE_SAW = 2'b00;
  localparam logic [1:0] WAVE_TRI = 2'b01;
  localparam logic [1:0] WAVE_SQR = 2'b10;
  localparam logic [1:0] WAVE_SIN = 2'b11;

  // First quadrant of round(127*sin(2*pi*(i+0.5)/256)); offset by half a step
  // so the mirrored quadrants meet symmetrically without duplicating samples.
  function automatic logic [6:0] sine_lut(input logic [LUT_AW-1:0] idx);
    logic [6:0] val;
    case (idx)
      6'd0:  val = 7'd2;    6'd1:  val = 7'd5;    6'd2:  val = 7'd8;    6'd3:  val = 7'd11;
      6'd4:  val = 7'd14;   6'd5:  val = 7'd17;   6'd6:  val = 7'd20;   6'd7:  val = 7'd23;
      6'd8:  val = 7'd26;   6'd9:  val = 7'd29;   6'd10: val = 7'd32;   6'd11: val = 7'd35;
      6'd12: val = 7'd38;   6'd13: val = 7'd41;   6'd14: val = 7'd44;   6'd15: val = 7'd47;
      6'd16: val = 7'd50;   6'd17: val = 7'd53;   6'd18: val = 7'd56;   6'd19: val = 7'd58;
      6'd20: val = 7'd61;   6'd21: val = 7'd64;   6'd22: val = 7'd67;   6'd23: val = 7'd69;
      6'd24: val = 7'd72;   6'd25: val = 7'd74;   6'd26: val = 7'd77;   6'd27: val = 7'd79;
      6'd28: val = 7'd82;   6'd29: val = 7'd84;   6'd30: val = 7'd86;   6'd31: val = 7'd89;
      6'd32: val = 7'd91;   6'd33: val = 7'd93;   6'd34: val = 7'd95;   6'd35: val = 7'd97;
      6'd36: val = 7'd99;   6'd37: val = 7'd101;  6'd38: val = 7'd103;  6'd39: val = 7'd105;
      6'd40: val = 7'd106;  6'd41: val = 7'd108;  6'd42: val = 7'd110;  6'd43: val = 7'd111;
      6'd44: val = 7'd113;  6'd45: val = 7'd114;  6'd46: val = 7'd115;  6'd47: val = 7'd117;
      6'd48: val = 7'd118;  6'd49: val = 7'd119;  6'd50: val = 7'd120;  6'd51: val = 7'd121;
      6'd52: val = 7'd122;  6'd53: val = 7'd123;  6'd54: val = 7'd124;  6'd55: val = 7'd124;
      6'd56: val = 7'd125;  6'd57: val = 7'd125;  6'd58: val = 7'd126;  6'd59: val = 7'd126;
      6'd60: val = 7'd127;  6'd61: val = 7'd127;  6'd62: val = 7'd127;  6'd63: val = 7'd127;
      default: val = 7'd0;
    endcase
    return val;
  endfunction

  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               phase_wrap_q, phase_wrap_d;
  logic               v1_q, v1_d;
  logic               v2_q, v2_d;
  logic [7:0]         raw_q, raw_d;
  logic [7:0]         sample_q, sample_d;
  logic               sample_valid_q, sample_valid_d;
  logic [PHASE_W-1:0] tune_sh_q, tune_sh_d;
  logic [1:0]         wave_sh_q, wave_sh_d;
  logic [7:0]         duty_sh_q, duty_sh_d;
  logic [7:0]         amp_sh_q, amp_sh_d;

  logic               fire_s;
  logic [PHASE_W:0]   sum_s;
  logic [7:0]         p_s;
  logic [LUT_AW-1:0]  sin_idx_s;
  logic [6:0]         sin_l_s;
  logic [7:0]         raw_s;
  logic signed [8:0]  diff_s;
  logic signed [17:0] prod_s;
  logic signed [17:0] shr_s;

  // Stage 1: phase accumulation and shadow configuration capture
  always_comb begin
    fire_s       = enable & advance;
    sum_s        = {1'b0, phase_q} + {1'b0, tune_sh_q};
    phase_d      = phase_q;
    phase_wrap_d = 1'b0;
    if (fire_s) begin
      phase_d      = sum_s[PHASE_W-1:0];
      phase_wrap_d = sum_s[PHASE_W];
    end else begin
      phase_d      = phase_q;
      phase_wrap_d = 1'b0;
    end
    v1_d = fire_s;

    // Config only changes while idle or at a period boundary, so a running
    // waveform never mixes settings within one cycle of the output.
    tune_sh_d = tune_sh_q;
    wave_sh_d = wave_sh_q;
    duty_sh_d = duty_sh_q;
    amp_sh_d  = amp_sh_q;
    if (!enable || phase_wrap_d) begin
      tune_sh_d = tune_word;
      wave_sh_d = wave_sel;
      duty_sh_d = duty;
      amp_sh_d  = amplitude;
    end else begin
      tune_sh_d = tune_sh_q;
      wave_sh_d = wave_sh_q;
      duty_sh_d = duty_sh_q;
      amp_sh_d  = amp_sh_q;
    end
  end

  // Stage 2: waveform shaping from the top 8 phase bits
  always_comb begin
    p_s       = phase_q[PHASE_W-1 -: 8];
    sin_idx_s = p_s[5:0];
    if (p_s[6]) begin
      sin_idx_s = 6'd63 - p_s[5:0];
    end else begin
      sin_idx_s = p_s[5:0];
    end
    sin_l_s = sine_lut(sin_idx_s);

    raw_s = 8'd0;
    case (wave_sh_q)
      WAVE_SAW: raw_s = p_s;
      WAVE_TRI: begin
        if (p_s[7]) begin
          raw_s = 8'd255 - {p_s[6:0], 1'b0};
        end else begin
          raw_s = {p_s[6:0], 1'b0};
        end
      end
      WAVE_SQR: begin
        if (p_s < duty_sh_q) begin
          raw_s = 8'd255;
        end else begin
          raw_s = 8'd0;
        end
      end
      WAVE_SIN: begin
        if (p_s[7]) begin
          raw_s = 8'd127 - {1'b0, sin_l_s};
        end else begin
          raw_s = 8'd128 + {1'b0, sin_l_s};
        end
      end
      default: raw_s = 8'd0;
    endcase

    if (v1_q) begin
      raw_d = raw_s;
    end else begin
      raw_d = raw_q;
    end
    v2_d = v1_q;
  end

  // Stage 3: amplitude scaling about midscale
  always_comb begin
    diff_s = $signed({1'b0, raw_q}) - 9'sd128;
    prod_s = $signed({{9{diff_s[8]}}, diff_s}) * $signed({10'd0, amp_sh_q});
    shr_s  = prod_s >>> 8;
    sample_d = sample_q;
    if (v2_q) begin
      if (amp_sh_q == 8'd255) begin
        sample_d = raw_q;
      end else begin
        sample_d = 8'd128 + shr_s[7:0];
      end
    end else begin
      sample_d = sample_q;
    end
    sample_valid_d = v2_q;
  end

  // Pipeline and configuration registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q        <= '0;
      phase_wrap_q   <= 1'b0;
      v1_q           <= 1'b0;
      v2_q           <= 1'b0;
      raw_q          <= 8'd0;
      sample_q       <= 8'd128;
      sample_valid_q <= 1'b0;
      tune_sh_q      <= '0;
      wave_sh_q      <= 2'b00;
      duty_sh_q      <= 8'd128;
      amp_sh_q       <= 8'd255;
    end else begin
      phase_q        <= phase_d;
      phase_wrap_q   <= phase_wrap_d;
      v1_q           <= v1_d;
      v2_q           <= v2_d;
      raw_q          <= raw_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
      tune_sh_q      <= tune_sh_d;
      wave_sh_q      <= wave_sh_d;
      duty_sh_q      <= duty_sh_d;
      amp_sh_q       <= amp_sh_d;
    end
  end

  assign sample       = sample_q;
  assign sample_valid = sample_valid_q;
  assign phase_wrap   = phase_wrap_q;

endmodule
